// File: rtl/sr_input_conditioner.sv
// Debounced set/reset conditioner feeding a downstream SR latch: two synchronized,
// FSM-debounced channels, conflict policy selected by SR_CONFLICT_HOLD_EN.
module sr_db_channel #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       raw,
   output logic       level,
   output logic [1:0] state_dbg
);
   typedef enum logic [1:0] {
      LOW      = 2'd0,
      RISE_CHK = 2'd1,
      HIGH     = 2'd2,
      FALL_CHK = 2'd3
   } db_state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   db_state_t        state;
   logic [1:0]       sync;
   logic [CNT_W-1:0] cnt;
   logic             synced;

   assign synced    = sync[1];
   assign level     = (state == HIGH) || (state == FALL_CHK);
   assign state_dbg = state;

   // cnt counts consecutive qualifying samples, including the one that left the stable state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= 2'b00;
         state <= LOW;
         cnt   <= '0;
      end else begin
         sync <= {sync[0], raw};
         case (state)
            LOW: begin
               if (synced) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     state <= HIGH;
                  end else begin
                     state <= RISE_CHK;
                     cnt   <= ONE;
                  end
               end
            end
            RISE_CHK: begin
               if (synced) begin
                  if (cnt == LAST) begin
                     state <= HIGH;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + ONE;
                  end
               end else begin
                  state <= LOW;
                  cnt   <= '0;
               end
            end
            HIGH: begin
               if (!synced) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     state <= LOW;
                  end else begin
                     state <= FALL_CHK;
                     cnt   <= ONE;
                  end
               end
            end
            FALL_CHK: begin
               if (!synced) begin
                  if (cnt == LAST) begin
                     state <= LOW;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + ONE;
                  end
               end else begin
                  state <= HIGH;
                  cnt   <= '0;
               end
            end
            default: begin
               state <= LOW;
               cnt   <= '0;
            end
         endcase
      end
   end
endmodule

module sr_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       set_raw,
   input  logic       reset_raw,
   output logic       s,
   output logic       r,
   output logic       conflict,
   output logic       set_evt,
   output logic       reset_evt,
   output logic [3:0] dbg_state
);
   logic       db_set;
   logic       db_reset;
   logic [1:0] set_state;
   logic [1:0] reset_state;
   logic       conflict_c;
   logic       s_c;
   logic       r_c;
   logic       s_d;
   logic       r_d;

   sr_db_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_set_ch (
      .clk(clk), .rst_n(rst_n), .raw(set_raw), .level(db_set), .state_dbg(set_state)
   );

   sr_db_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_reset_ch (
      .clk(clk), .rst_n(rst_n), .raw(reset_raw), .level(db_reset), .state_dbg(reset_state)
   );

   assign dbg_state  = {set_state, reset_state};
   assign conflict_c = db_set & db_reset;

`ifdef SR_CONFLICT_HOLD_EN
   // Both requests active: drive neither input so the latch keeps its state.
   assign s_c = db_set & ~conflict_c;
   assign r_c = db_reset & ~conflict_c;
`else
   assign s_c = db_set & ~db_reset;
   assign r_c = db_reset;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s         <= 1'b0;
         r         <= 1'b0;
         conflict  <= 1'b0;
         s_d       <= 1'b0;
         r_d       <= 1'b0;
         set_evt   <= 1'b0;
         reset_evt <= 1'b0;
      end else begin
         s         <= s_c;
         r         <= r_c;
         conflict  <= conflict_c;
         s_d       <= s;
         r_d       <= r;
         set_evt   <= s & ~s_d;
         reset_evt <= r & ~r_d;
      end
   end
endmodule

// File: tb/tb_sr_input_conditioner.sv
// Bench for sr_input_conditioner at DEBOUNCE_CYCLES=4; expected output vectors
// {s,r,conflict,set_evt,reset_evt} are queued per edge and compared 1 ns after each edge.
module tb_sr_input_conditioner;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       set_raw = 1'b0;
   logic       reset_raw = 1'b0;
   logic       s, r, conflict, set_evt, reset_evt;
   logic [3:0] dbg_state;
   logic [4:0] obs;

   int checks = 0;
   int errors = 0;
   logic [4:0] exp_q[$];

`ifdef SR_CONFLICT_HOLD_EN
   localparam logic [4:0] CONF     = 5'b00100;
   localparam logic [4:0] CONF_EVT = 5'b00100;
`else
   localparam logic [4:0] CONF     = 5'b01100;
   localparam logic [4:0] CONF_EVT = 5'b01101;
`endif

   sr_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .set_raw(set_raw), .reset_raw(reset_raw),
      .s(s), .r(r), .conflict(conflict), .set_evt(set_evt), .reset_evt(reset_evt),
      .dbg_state(dbg_state)
   );

   assign obs = {s, r, conflict, set_evt, reset_evt};

   always #5 clk = ~clk;

   task automatic push_n(input logic [4:0] v, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(v);
   endtask

   task automatic test_reset();
      logic [4:0] e;
      set_raw   = 1'b1;
      reset_raw = 1'b1;
      push_n(5'b00000, 4);
      for (int k = 1; exp_q.size() > 0; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reset edge %0d: got %b expected %b", k, obs, e);
         end
      end
      set_raw   = 1'b0;
      reset_raw = 1'b0;
      rst_n     = 1'b1;
   endtask

   task automatic test_set_rise();
      logic [4:0] e;
      set_raw = 1'b1;
      push_n(5'b00000, D + 2);
      push_n(5'b10000, 1);
      push_n(5'b10010, 1);
      push_n(5'b10000, 2);
      for (int k = 1; exp_q.size() > 0; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL set_rise edge %0d: got %b expected %b", k, obs, e);
         end
      end
   endtask

   task automatic test_set_fall();
      logic [4:0] e;
      set_raw = 1'b0;
      push_n(5'b10000, D + 2);
      push_n(5'b00000, 4);
      for (int k = 1; exp_q.size() > 0; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL set_fall edge %0d: got %b expected %b", k, obs, e);
         end
      end
   endtask

   task automatic test_bounce();
      logic [4:0] e;
      for (int hi = 1; hi < D; hi++) begin
         set_raw = 1'b1;
         push_n(5'b00000, 12);
         for (int k = 1; exp_q.size() > 0; k++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
               errors++;
               $display("FAIL bounce_%0d edge %0d: got %b expected %b", hi, k, obs, e);
            end
            if (k == hi) set_raw = 1'b0;
         end
      end
   endtask

   task automatic test_reset_rise();
      logic [4:0] e;
      reset_raw = 1'b1;
      push_n(5'b00000, D + 2);
      push_n(5'b01000, 1);
      push_n(5'b01001, 1);
      push_n(5'b01000, D + 3);
      push_n(5'b00000, 3);
      for (int k = 1; exp_q.size() > 0; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reset_rise edge %0d: got %b expected %b", k, obs, e);
         end
         if (k == 9) reset_raw = 1'b0;
      end
   endtask

   task automatic test_conflict();
      logic [4:0] e;
      set_raw = 1'b1;
      push_n(5'b00000, 6);
      push_n(5'b10000, 1);
      push_n(5'b10010, 1);
      push_n(5'b10000, 7);
      push_n(CONF, 1);
      push_n(CONF_EVT, 1);
      push_n(CONF, 7);
      push_n(5'b00000, 3);
      for (int k = 1; exp_q.size() > 0; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL conflict edge %0d: got %b expected %b", k, obs, e);
         end
         if (s === 1'b1 && r === 1'b1) begin
            errors++;
            $display("FAIL s_r_exclusive edge %0d: got s=1 r=1 expected not both", k);
         end
         if (k == 9) reset_raw = 1'b1;
         if (k == 18) begin
            set_raw   = 1'b0;
            reset_raw = 1'b0;
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [4:0] e;
      set_raw = 1'b1;
      push_n(5'b00000, 3);
      for (int k = 1; exp_q.size() > 0; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL mid_qual edge %0d: got %b expected %b", k, obs, e);
         end
      end
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      push_n(5'b00000, D + 2);
      push_n(5'b10000, 1);
      push_n(5'b10010, 1);
      push_n(5'b10000, 2);
      for (int k = 1; exp_q.size() > 0; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL requal edge %0d: got %b expected %b", k, obs, e);
         end
      end
      // Asynchronous clear while s is high, between clock edges.
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== 5'b00000) begin
         errors++;
         $display("FAIL async_clear: got %b expected %b", obs, 5'b00000);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      set_raw = 1'b0;
      push_n(5'b00000, 10);
      for (int k = 1; exp_q.size() > 0; k++) begin
         @(posedge clk); #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL post_clear edge %0d: got %b expected %b", k, obs, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_set_rise();
      test_set_fall();
      test_bounce();
      test_reset_rise();
      test_conflict();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
